// File: rtl/vga_fb_arbiter_if.sv
// Bundle of timing-gen inputs, writer/clear handshakes, RAM port and DAC outputs
// for the framebuffer arbiter. slave = arbiter side, master = environment side.
interface vga_fb_arbiter_if #(
  parameter int AW = 15,
  parameter int DW = 12
);
  // timing generator
  logic          valid;
  logic [9:0]    h_cnt;
  logic [9:0]    v_cnt;
  logic          hsync_in;
  logic          vsync_in;
  // writer
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  // clear engine
  logic          clr_start;
  logic [DW-1:0] clr_color;
  logic          clr_busy;
  // single-port RAM
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  // DAC
  logic [DW-1:0] pix_rgb;
  logic          pix_valid;
  logic          hsync_out;
  logic          vsync_out;

  modport slave (
    input  valid, h_cnt, v_cnt, hsync_in, vsync_in,
    input  wr_req, wr_addr, wr_data,
    output wr_ack,
    input  clr_start, clr_color,
    output clr_busy,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata,
    output pix_rgb, pix_valid, hsync_out, vsync_out
  );

  modport master (
    output valid, h_cnt, v_cnt, hsync_in, vsync_in,
    output wr_req, wr_addr, wr_data,
    input  wr_ack,
    output clr_start, clr_color,
    input  clr_busy,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata,
    input  pix_rgb, pix_valid, hsync_out, vsync_out
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port video RAM arbiter: display scan-out owns every slot where a new
// 4x4 block starts; the writer or the clear engine gets the remaining slots.
// Scan-out path: address reg -> RAM -> pixel reg, matched by 3-deep sync pipes.
module vga_fb_arbiter #(
  parameter int FB_W  = 160,
  parameter int FB_H  = 120,
  parameter int SHIFT = 2,
  parameter int AW    = 15,
  parameter int DW    = 12
) (
  input logic            pclk,
  input logic            reset,
  vga_fb_arbiter_if.slave bus
);
  localparam int FB_N = FB_W * FB_H;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } mem_cmd_t;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic [DW-1:0] clr_color_q, clr_color_d;
  logic          clr_busy_q, clr_busy_d;
  logic          wr_ack_q, wr_ack_d;
  mem_cmd_t      mem_q, mem_d;
  logic [DW-1:0] pix_q, pix_d;
  logic [1:0]    rd_pipe_q;
  logic [2:0]    vld_pipe_q, hs_pipe_q, vs_pipe_q;

  logic          disp_slot;
  logic [9:0]    fx, fy;
  logic [AW-1:0] disp_addr;
  logic          wr_in_range;
  logic          wr_grant;
  logic          clr_last;

  // Slot decode: a display read is needed only on the first column of each block.
  always_comb begin
    disp_slot   = bus.valid && (bus.h_cnt[SHIFT-1:0] == '0);
    fx          = bus.h_cnt >> SHIFT;
    fy          = bus.v_cnt >> SHIFT;
    disp_addr   = AW'(fy) * AW'(FB_W) + AW'(fx);
    wr_in_range = int'(bus.wr_addr) < FB_N;
    // wr_ack_q high means the held request was just consumed; skip it this cycle.
    wr_grant    = (state_q == ST_IDLE) && !disp_slot && bus.wr_req && !wr_ack_q;
    clr_last    = (clr_cnt_q == AW'(FB_N - 1));
  end

  // Next-state: RAM command priority display > writer/clear, plus clear FSM.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    clr_color_d = clr_color_q;
    wr_ack_d    = 1'b0;
    mem_d       = mem_q;
    mem_d.we    = 1'b0;

    if (disp_slot) begin
      mem_d.addr = disp_addr;
    end else if (wr_grant) begin
      // Out-of-range writes are acked but dropped; address is left untouched.
      wr_ack_d = 1'b1;
      if (wr_in_range) begin
        mem_d.we   = 1'b1;
        mem_d.addr = bus.wr_addr;
        mem_d.data = bus.wr_data;
      end
    end else if (state_q == ST_CLEAR) begin
      mem_d.we   = 1'b1;
      mem_d.addr = clr_cnt_q;
      mem_d.data = clr_color_q;
      clr_cnt_d  = clr_cnt_q + 1'b1;
      if (clr_last) state_d = ST_IDLE;
    end

    // A write granted in this same cycle still goes out; clearing starts next cycle.
    if ((state_q == ST_IDLE) && bus.clr_start) begin
      state_d     = ST_CLEAR;
      clr_color_d = bus.clr_color;
      clr_cnt_d   = '0;
    end

    clr_busy_d = (state_d == ST_CLEAR);
    pix_d      = rd_pipe_q[1] ? bus.mem_rdata : pix_q;
  end

  // State, RAM command, pixel register and delay pipes.
  always_ff @(posedge pclk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      clr_cnt_q   <= '0;
      clr_color_q <= '0;
      clr_busy_q  <= 1'b0;
      wr_ack_q    <= 1'b0;
      mem_q       <= '0;
      pix_q       <= '0;
      rd_pipe_q   <= '0;
      vld_pipe_q  <= '0;
      hs_pipe_q   <= '0;
      vs_pipe_q   <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_color_q <= clr_color_d;
      clr_busy_q  <= clr_busy_d;
      wr_ack_q    <= wr_ack_d;
      mem_q       <= mem_d;
      pix_q       <= pix_d;
      rd_pipe_q   <= {rd_pipe_q[0], disp_slot};
      vld_pipe_q  <= {vld_pipe_q[1:0], bus.valid};
      hs_pipe_q   <= {hs_pipe_q[1:0], bus.hsync_in};
      vs_pipe_q   <= {vs_pipe_q[1:0], bus.vsync_in};
    end
  end

  assign bus.wr_ack    = wr_ack_q;
  assign bus.clr_busy  = clr_busy_q;
  assign bus.mem_addr  = mem_q.addr;
  assign bus.mem_we    = mem_q.we;
  assign bus.mem_wdata = mem_q.data;
  assign bus.pix_valid = vld_pipe_q[2];
  assign bus.hsync_out = hs_pipe_q[2];
  assign bus.vsync_out = vs_pipe_q[2];
  assign bus.pix_rgb   = vld_pipe_q[2] ? pix_q : '0;
endmodule
